// File: rtl/arc4_sequencer_if.sv
// Upstream start handshake for arc4_sequencer.
// master: en/key out, rdy/err/phase/cycles in; slave: the sequencer side.
interface arc4_sequencer_if #(
  parameter int KEY_W = 24
);
  logic             en;
  logic             rdy;
  logic [KEY_W-1:0] key;
  logic             err;
  logic [1:0]       phase;
  logic [31:0]      cycles;

  modport master (
    output en, key,
    input  rdy, err, phase, cycles
  );

  modport slave (
    input  en, key,
    output rdy, err, phase, cycles
  );
endinterface

// File: rtl/arc4_sequencer.sv
// ARC4 run sequencer: starts init, ksa, prga in turn and owns the S-memory mux.
// Ports: clk/rst, upstream if (en/rdy/key/err/phase/cycles), child en/rdy, S-mem.
module arc4_sequencer #(
  parameter int KEY_W   = 24,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  arc4_sequencer_if.slave   up,
  output logic              init_en,
  output logic              ksa_en,
  output logic              prga_en,
  input  logic              init_rdy,
  input  logic              ksa_rdy,
  input  logic              prga_rdy,
  output logic [KEY_W-1:0]  ksa_key,
  output logic [KEY_W-1:0]  prga_key,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] init_wrdata,
  input  logic [DATA_W-1:0] ksa_wrdata,
  input  logic [DATA_W-1:0] prga_wrdata,
  input  logic              init_wren,
  input  logic              ksa_wren,
  input  logic              prga_wren,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wrdata,
  output logic              s_wren
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INIT_GO   = 3'd1;
  localparam logic [2:0] INIT_WAIT = 3'd2;
  localparam logic [2:0] KSA_GO    = 3'd3;
  localparam logic [2:0] KSA_WAIT  = 3'd4;
  localparam logic [2:0] PRGA_GO   = 3'd5;
  localparam logic [2:0] PRGA_WAIT = 3'd6;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [2:0]       state_n;
  logic [KEY_W-1:0] key_q;
  logic             err_q;
  logic [31:0]      cyc_q;
  logic             seen_busy;
  logic [15:0]      wdog;

  logic in_init;
  logic in_ksa;
  logic in_prga;
  logic go;
  logic wait_st;
  logic cur_rdy;
  logic wren_mux;
  logic done;
  logic tmo;
  logic accept;

  assign in_init = (state == INIT_GO) || (state == INIT_WAIT);
  assign in_ksa  = (state == KSA_GO)  || (state == KSA_WAIT);
  assign in_prga = (state == PRGA_GO) || (state == PRGA_WAIT);

  assign go = (state == INIT_GO) || (state == KSA_GO) ||
              (state == PRGA_GO);
  assign wait_st = (state == INIT_WAIT) || (state == KSA_WAIT) ||
                   (state == PRGA_WAIT);

  // A ready seen before the child ever went busy is its idle
  // state, not completion.
  assign done   = wait_st && seen_busy && cur_rdy;
  assign tmo    = wait_st && !done && (wdog == WD_LAST);
  assign accept = (state == IDLE) && up.en;

  always_comb begin
    cur_rdy  = 1'b0;
    s_addr   = '0;
    s_wrdata = '0;
    wren_mux = 1'b0;
    unique case (1'b1)
      in_init: begin
        cur_rdy  = init_rdy;
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
        wren_mux = init_wren;
      end
      in_ksa: begin
        cur_rdy  = ksa_rdy;
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
        wren_mux = ksa_wren;
      end
      in_prga: begin
        cur_rdy  = prga_rdy;
        s_addr   = prga_addr;
        s_wrdata = prga_wrdata;
        wren_mux = prga_wren;
      end
      default: ;
    endcase
  end

  // Writes and starts are blocked during the reset cycle itself.
  assign s_wren  = wren_mux && !rst;
  assign init_en = (state == INIT_GO) && init_rdy && !rst;
  assign ksa_en  = (state == KSA_GO)  && ksa_rdy  && !rst;
  assign prga_en = (state == PRGA_GO) && prga_rdy && !rst;

  always_comb begin
    state_n = state;
    unique case (1'b1)
      state == IDLE: begin
        if (up.en) state_n = INIT_GO;
      end
      go: begin
        if (cur_rdy) state_n = state + 3'd1;
      end
      wait_st: begin
        if (done)
          state_n = (state == PRGA_WAIT) ? IDLE : state + 3'd1;
        else if (tmo)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_q     <= '0;
      err_q     <= 1'b0;
      cyc_q     <= '0;
      seen_busy <= 1'b0;
      wdog      <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        key_q <= up.key;
        err_q <= 1'b0;
        cyc_q <= '0;
      end else if (state != IDLE && cyc_q != '1) begin
        cyc_q <= cyc_q + 32'd1;
      end
      if (tmo) err_q <= 1'b1;
      if (wait_st) begin
        if (done || tmo)
          seen_busy <= 1'b0;
        else if (!cur_rdy)
          seen_busy <= 1'b1;
      end
      if (go)
        wdog <= '0;
      else if (wait_st)
        wdog <= (done || tmo) ? 16'd0 : wdog + 16'd1;
    end
  end

  assign up.rdy    = (state == IDLE);
  assign up.err    = err_q;
  assign up.cycles = cyc_q;
  assign up.phase  = in_prga ? 2'd3 :
                     in_ksa  ? 2'd2 :
                     in_init ? 2'd1 : 2'd0;
  assign ksa_key   = key_q;
  assign prga_key  = key_q;

endmodule

// File: tb/tb_arc4_sequencer.sv
// Testbench for arc4_sequencer with behavioural init/ksa/prga children.
// Second instance uses a short watchdog to exercise the abort path.
module tb_arc4_sequencer;
  localparam int KW = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arc4_sequencer_if #(.KEY_W(KW)) up ();
  arc4_sequencer_if #(.KEY_W(KW)) up2 ();

  logic [5:0]  c_en;
  logic [5:0]  c_rdy;
  logic [5:0]  hold;
  int unsigned busy [6];
  int unsigned cnt [6];

  logic [KW-1:0] ksa_key, prga_key, ksa_key2, prga_key2;
  logic [7:0] init_addr, ksa_addr, prga_addr;
  logic [7:0] init_wd, ksa_wd, prga_wd;
  logic       init_we, ksa_we, prga_we;
  logic [7:0] s_addr, s_wd, s_addr2, s_wd2;
  logic       s_we, s_we2;
  logic [7:0] z8;

  arc4_sequencer dut (
    .clk(clk), .rst(rst), .up(up),
    .init_en(c_en[0]), .ksa_en(c_en[1]), .prga_en(c_en[2]),
    .init_rdy(c_rdy[0]), .ksa_rdy(c_rdy[1]), .prga_rdy(c_rdy[2]),
    .ksa_key(ksa_key), .prga_key(prga_key),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
    .init_wrdata(init_wd), .ksa_wrdata(ksa_wd), .prga_wrdata(prga_wd),
    .init_wren(init_we), .ksa_wren(ksa_we), .prga_wren(prga_we),
    .s_addr(s_addr), .s_wrdata(s_wd), .s_wren(s_we)
  );

  arc4_sequencer #(.TIMEOUT(100)) dut2 (
    .clk(clk), .rst(rst), .up(up2),
    .init_en(c_en[3]), .ksa_en(c_en[4]), .prga_en(c_en[5]),
    .init_rdy(c_rdy[3]), .ksa_rdy(c_rdy[4]), .prga_rdy(c_rdy[5]),
    .ksa_key(ksa_key2), .prga_key(prga_key2),
    .init_addr(z8), .ksa_addr(z8), .prga_addr(z8),
    .init_wrdata(z8), .ksa_wrdata(z8), .prga_wrdata(z8),
    .init_wren(1'b0), .ksa_wren(1'b0), .prga_wren(1'b0),
    .s_addr(s_addr2), .s_wrdata(s_wd2), .s_wren(s_we2)
  );

  // Child: idle-ready; a start makes it busy for busy[i] cycles.
  always @(posedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (rst)
        cnt[i] <= 0;
      else if (c_en[i] && c_rdy[i])
        cnt[i] <= busy[i];
      else if (cnt[i] != 0)
        cnt[i] <= cnt[i] - 1;
    end
  end

  always_comb begin
    c_rdy = '0;
    for (int i = 0; i < 6; i++)
      c_rdy[i] = (cnt[i] == 0) && !hold[i];
  end

  int seq [$];
  always @(posedge clk) begin
    if (!rst)
      for (int i = 0; i < 3; i++)
        if (c_en[i]) seq.push_back(i);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: each child costs one start cycle, its busy time,
  // and one cycle in which ready is seen again.
  function automatic int unsigned ref_cycles(int unsigned b0,
                                             int unsigned b1,
                                             int unsigned b2);
    return (b0 + 2) + (b1 + 2) + (b2 + 2);
  endfunction

  function automatic bit seq_ok();
    return seq.size() == 3 && seq[0] == 0 && seq[1] == 1 &&
           seq[2] == 2;
  endfunction

  task automatic run(string tag, logic [KW-1:0] k,
                     int unsigned b0, int unsigned b1,
                     int unsigned b2, int unsigned exp, bit mid);
    int n;
    busy[0] = b0;
    busy[1] = b1;
    busy[2] = b2;
    seq.delete();
    @(negedge clk);
    up.en  = 1'b1;
    up.key = k;
    @(negedge clk);
    up.en  = 1'b0;
    up.key = ~k;
    n = 0;
    while (!up.rdy && n < 5000) begin
      up.en = (mid && n == 20);
      @(negedge clk);
      n++;
    end
    up.en = 1'b0;
    chk({tag, " finished"}, 64'(n < 5000), 64'd1);
    chk({tag, " cycles"}, 64'(up.cycles), 64'(exp));
    chk({tag, " err"}, 64'(up.err), 64'd0);
    chk({tag, " order"}, 64'(seq_ok()), 64'd1);
    chk({tag, " ksa_key"}, 64'(ksa_key), 64'(k));
    chk({tag, " prga_key"}, 64'(prga_key), 64'(k));
  endtask

  typedef struct {
    logic [KW-1:0] key;
    int unsigned   b0;
    int unsigned   b1;
    int unsigned   b2;
    int unsigned   exp;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int n;
    int bad;
    int unsigned rb0, rb1, rb2;
    logic [KW-1:0] rk;

    tbl[0] = '{24'h00033C, 256, 768, 300, 1330};
    tbl[1] = '{24'h123456, 1, 1, 1, 9};
    tbl[2] = '{24'hABCDEF, 10, 3, 7, 26};
    tbl[3] = '{24'hFFFFFF, 50, 2, 100, 158};

    up.en = 1'b0;  up.key = '0;
    up2.en = 1'b0; up2.key = '0;
    hold = '0;
    z8 = '0;
    for (int i = 0; i < 6; i++) busy[i] = 1;
    init_addr = 8'h11; ksa_addr = 8'h22; prga_addr = 8'h33;
    init_wd = 8'h44;   ksa_wd = 8'h55;   prga_wd = 8'h66;
    init_we = 1'b0;    ksa_we = 1'b0;    prga_we = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset rdy", 64'(up.rdy), 64'd1);
    chk("reset err", 64'(up.err), 64'd0);
    chk("reset cycles", 64'(up.cycles), 64'd0);
    chk("reset phase", 64'(up.phase), 64'd0);
    chk("reset s_wren", 64'(s_we), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++)
      run($sformatf("vec%0d", i), tbl[i].key, tbl[i].b0,
          tbl[i].b1, tbl[i].b2, tbl[i].exp, (i == 0));

    for (int i = 0; i < 4; i++) begin
      rb0 = $urandom_range(1, 40);
      rb1 = $urandom_range(1, 40);
      rb2 = $urandom_range(1, 40);
      rk  = KW'($urandom);
      run($sformatf("rnd%0d", i), rk, rb0, rb1, rb2,
          ref_cycles(rb0, rb1, rb2), 1'b1);
    end

    // ksa held not-ready when it is due to start
    busy[0] = 3; busy[1] = 3; busy[2] = 3;
    hold[1] = 1'b1;
    seq.delete();
    @(negedge clk);
    up.en = 1'b1; up.key = 24'h0F0F0F;
    @(negedge clk);
    up.en = 1'b0;
    n = 0;
    while (up.phase != 2'd2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("stall reach ksa", 64'(n < 200), 64'd1);
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (c_en[1]) bad++;
    end
    chk("stall no ksa_en", 64'(bad), 64'd0);
    chk("stall phase", 64'(up.phase), 64'd2);
    chk("stall pulses", 64'(seq.size()), 64'd1);
    hold[1] = 1'b0;
    n = 0;
    while (!up.rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("stall order", 64'(seq_ok()), 64'd1);

    // back-to-back with en held high
    busy[0] = 1; busy[1] = 1; busy[2] = 1;
    @(negedge clk);
    up.en = 1'b1;
    @(negedge clk);
    n = 0;
    while (!up.rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b2b idle gap", 64'(up.phase), 64'd0);
    @(negedge clk);
    chk("b2b reaccept", 64'(up.phase), 64'd1);
    up.en = 1'b0;
    n = 0;
    while (!up.rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b2b second done", 64'(up.cycles), 64'd9);

    // memory mux in KSA_WAIT, then reset mid-run
    busy[0] = 2; busy[1] = 50; busy[2] = 2;
    seq.delete();
    @(negedge clk);
    up.en = 1'b1; up.key = 24'h5A5A5A;
    @(negedge clk);
    up.en = 1'b0;
    n = 0;
    while (!(seq.size() == 2 && up.phase == 2'd2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mux reach ksa_wait", 64'(n < 200), 64'd1);
    ksa_addr = 8'hA5; ksa_wd = 8'h3C; ksa_we = 1'b1;
    init_we = 1'b1;   init_addr = 8'h11;
    #1;
    chk("mux s_addr", 64'(s_addr), 64'hA5);
    chk("mux s_wrdata", 64'(s_wd), 64'h3C);
    chk("mux s_wren", 64'(s_we), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst same-cycle s_wren", 64'(s_we), 64'd0);
    chk("rst same-cycle en", 64'(c_en[2:0]), 64'd0);
    @(negedge clk);
    chk("rst rdy", 64'(up.rdy), 64'd1);
    chk("rst phase", 64'(up.phase), 64'd0);
    chk("rst en", 64'(c_en[2:0]), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle s_wren", 64'(s_we), 64'd0);
    chk("idle s_addr", 64'(s_addr), 64'd0);
    ksa_we = 1'b0; init_we = 1'b0;
    run("after rst", 24'h00033C, 4, 5, 6, ref_cycles(4, 5, 6), 1'b0);

    // watchdog abort on the short-timeout instance
    busy[3] = 5; busy[4] = 5; busy[5] = 32'h0FFF_FFFF;
    @(negedge clk);
    up2.en = 1'b1; up2.key = 24'h000001;
    @(negedge clk);
    up2.en = 1'b0;
    n = 0;
    while (!c_en[5] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wd prga start", 64'(n < 200), 64'd1);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (up2.phase != 2'd3) break;
      n++;
    end
    chk("wd wait cycles", 64'(n), 64'd100);
    chk("wd err", 64'(up2.err), 64'd1);
    chk("wd rdy", 64'(up2.rdy), 64'd1);
    chk("wd cycles", 64'(up2.cycles), 64'd115);
    up2.en = 1'b1;
    @(negedge clk);
    up2.en = 1'b0;
    chk("wd err cleared", 64'(up2.err), 64'd0);
    chk("wd restarted", 64'(up2.phase), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
